rv32i_id_operand_fetch: RTL and testbench
=========================================

Name: rv32i_id_operand_fetch

Overview:
Decode/operand-fetch stage of the rv32i 5-stage pipeline. It is the consumer end of the data-forwarding interface that the EX, MEM and WB stages drive. It holds the 32x32 register file, takes writeback from wbTop, and resolves rs1/rs2 with a priority bypass from the forwarded EX, MEM and WB buses. It detects load-use hazards, stalls fetch for one cycle, and registers operands plus control into the ID/EX pipeline register.

Parameters:
DATA_W, 32, datapath / register width
NOP_IW, 32'h00000013, instruction word injected as a bubble (addi x0,x0,0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
pc_in  in  32  PC from IF stage
iw_in  in  32  instruction word from IF stage
df_ex_enable  in  1  EX-stage writeback enable (forwarded)
df_ex_reg  in  5  EX-stage destination register
df_ex_data  in  32  EX-stage result
df_ex_is_load  in  1  EX-stage instruction is a LOAD (data not yet valid)
df_mem_enable  in  1  MEM-stage writeback enable
df_mem_reg  in  5  MEM-stage destination register
df_mem_data  in  32  MEM-stage result
wb_en_in  in  1  WB-stage register-file write enable
wb_reg_in  in  5  WB destination register
wb_data_in  in  32  WB write data
stall_out  out  1  combinational; IF must hold PC/IW this cycle
pc_out  out  32  to EX
iw_out  out  32  to EX
rs1_data_out  out  32  resolved rs1 operand
rs2_data_out  out  32  resolved rs2 operand
wb_en_out  out  1  instruction writes rd
wb_reg_out  out  5  rd

Behaviour:
- Reset (clk, reset synchronous active-high): all 32 registers cleared to 0. pc_out, iw_out, rs1_data_out, rs2_data_out, wb_reg_out = 0. wb_en_out = 0.
- Field extraction: rs1=iw_in[19:15], rs2=iw_in[24:20], rd=iw_in[11:7], opcode=iw_in[6:0].
- Register file: on posedge with wb_en_in=1 and wb_reg_in!=0, write wb_data_in. Writes to x0 are ignored; reads of x0 always return 0.
- Operand resolve, per source, combinational, first match wins:
  - addr==0 -> 0
  - df_ex_enable && df_ex_reg==addr -> df_ex_data
  - df_mem_enable && df_mem_reg==addr -> df_mem_data
  - wb_en_in && wb_reg_in==addr -> wb_data_in (write-through in the same cycle)
  - otherwise the register-file value.
- Source usage:
  - rs1 used by all opcodes except LUI(0110111), AUIPC(0010111), JAL(1101111).
  - rs2 used only by OP(0110011), STORE(0100011), BRANCH(1100011).
- Writes-rd decode: LUI, AUIPC, JAL, JALR(1100111), LOAD(0000011), OP-IMM(0010011), OP give wb_en=1. All other opcodes give 0. rd==0 forces wb_en=0.
- Load-use hazard:
  - Condition: stall_out=1 when df_ex_is_load && df_ex_enable && df_ex_reg!=0 && df_ex_reg matches a used source.
  - While stalled, the ID/EX register loads a bubble: iw_out=NOP_IW, pc_out=pc_in, wb_en_out=0, wb_reg_out=0, operands=0.
  - Next cycle the load sits in MEM, so the hazard clears via MEM forwarding. Stall length is exactly 1 cycle per load.
- Otherwise: ID/EX register loads pc_in, iw_in, resolved operands, decoded wb_en/rd. Latency is 1 cycle.
- Simultaneous WB write to register R and ID read of R: the bypassed WB value is used, not the stale array value.
- Reset asserted mid-stall: reset wins. Outputs are zeroed and stall_out is ignored by the register.

Optional Feature:
RV32I_ID_PERF_CNT_EN
- Defined: adds output ports stall_cnt (32) and fwd_cnt (32).
  - stall_cnt increments on each cycle with stall_out=1.
  - fwd_cnt increments on each non-stall cycle where at least one used source took an EX or MEM bypass.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP
  - NOP_IW constant
  - typedef for the 5-bit register index
- One sub-module, rv32i_regfile: 32x32 array with synchronous write, async read of 2 ports, x0 hardwired. Bypass and hazard logic stay in the top.

Test Plan:
- Reset then WB write x5=0xDEADBEEF, next iw=add x6,x5,x0 -> rs1_data_out=0xDEADBEEF; rs2_data_out=0.
- Same-cycle hazards: df_ex(x7=0x11), df_mem(x7=0x22), wb(x7=0x33) all active; iw uses rs1=x7 -> rs1_data_out=0x11. Drop EX -> 0x22. Drop MEM -> 0x33.
- Load-use: df_ex_is_load=1, df_ex_reg=x9, iw=sw x9,0(x1) -> stall_out=1; next iw_out=0x00000013, wb_en_out=0. Then with the load in MEM (df_mem x9=0x55), re-presented iw -> rs2_data_out=0x55, stall_out=0.
- No false stall: load to x9 in EX, iw=lui x9,0x12345 -> stall_out=0.
- x0 protection: wb write x0=0xFFFFFFFF and df_ex_reg=0 enabled; iw reads x0 -> operands 0. addi x0,... -> wb_en_out=0.
- Reset asserted during stall cycle -> all outputs 0 next cycle. Regfile reads 0 afterwards.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, bubble instruction word and register-index type
// shared by the rv32i decode/operand-fetch slice.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0: the bubble injected on a load-use stall
  localparam logic [31:0] NOP_IW = 32'h0000_0013;

  typedef logic [4:0] reg_idx_t;

  // Opcodes whose rd field is a real destination
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    return (opc == OPC_LUI)  || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
           (opc == OPC_JALR) || (opc == OPC_LOAD)  || (opc == OPC_OPIMM) ||
           (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32-entry register file, one synchronous write port and
// two asynchronous read ports; x0 is hardwired to zero.
module rv32i_regfile
  import rv32i_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  reg_idx_t          raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_reg [32];

  // Clear everything on reset, otherwise write any register except x0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // x0 reads as zero regardless of array contents
  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_reg[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_reg[raddr_b];

endmodule

// File: rtl/rv32i_id_operand_fetch.sv
// rv32i_id_operand_fetch: decode / operand-fetch stage. Resolves rs1/rs2
// through an EX > MEM > WB > regfile bypass, stalls one cycle on load-use
// and registers operands plus control into the ID/EX register.
// Optional build macro: RV32I_ID_PERF_CNT_EN adds stall_cnt / fwd_cnt.
module rv32i_id_operand_fetch #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] NOP_IW = rv32i_pkg::NOP_IW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       iw_in,
  input  logic              df_ex_enable,
  input  logic [4:0]        df_ex_reg,
  input  logic [DATA_W-1:0] df_ex_data,
  input  logic              df_ex_is_load,
  input  logic              df_mem_enable,
  input  logic [4:0]        df_mem_reg,
  input  logic [DATA_W-1:0] df_mem_data,
  input  logic              wb_en_in,
  input  logic [4:0]        wb_reg_in,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic              stall_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       iw_out,
  output logic [DATA_W-1:0] rs1_data_out,
  output logic [DATA_W-1:0] rs2_data_out,
  output logic              wb_en_out,
  output logic [4:0]        wb_reg_out
`ifdef RV32I_ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  import rv32i_pkg::*;

  logic [6:0]        opcode;
  reg_idx_t          rd;
  reg_idx_t          rs_addr [2];
  logic [DATA_W-1:0] rf_data [2];
  logic [DATA_W-1:0] rs_val  [2];
  logic              rs_used [2];
  logic              wb_en_dec;

  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       iw_reg, iw_next;
  logic [DATA_W-1:0] rs1_reg, rs1_next;
  logic [DATA_W-1:0] rs2_reg, rs2_next;
  logic              wb_en_reg, wb_en_next;
  reg_idx_t          wb_reg_reg, wb_reg_next;

  assign opcode     = iw_in[6:0];
  assign rd         = iw_in[11:7];
  assign rs_addr[0] = iw_in[19:15];
  assign rs_addr[1] = iw_in[24:20];

  assign rs_used[0] = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
  assign rs_used[1] = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign wb_en_dec  = opc_writes_rd(opcode) && (rd != 5'd0);

  rv32i_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en_in),
    .waddr   (wb_reg_in),
    .wdata   (wb_data_in),
    .raddr_a (rs_addr[0]),
    .rdata_a (rf_data[0]),
    .raddr_b (rs_addr[1]),
    .rdata_b (rf_data[1])
  );

  // Per-source bypass: youngest producer wins, WB write-through beats the array
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resolve
      logic ex_hit, mem_hit, wb_hit;
      assign ex_hit  = df_ex_enable  && (df_ex_reg  == rs_addr[gi]);
      assign mem_hit = df_mem_enable && (df_mem_reg == rs_addr[gi]);
      assign wb_hit  = wb_en_in      && (wb_reg_in  == rs_addr[gi]);
      assign rs_val[gi] = (rs_addr[gi] == 5'd0) ? '0          :
                          ex_hit                ? df_ex_data  :
                          mem_hit               ? df_mem_data :
                          wb_hit                ? wb_data_in  :
                                                  rf_data[gi];
    end
  endgenerate

  // A load in EX has no data yet; hold IF one cycle until it reaches MEM
  assign stall_out = df_ex_is_load && df_ex_enable && (df_ex_reg != 5'd0) &&
                     ((rs_used[0] && (df_ex_reg == rs_addr[0])) ||
                      (rs_used[1] && (df_ex_reg == rs_addr[1])));

  // Next ID/EX contents: the decoded instruction, or a bubble while stalled
  always_comb begin
    pc_next     = pc_in;
    iw_next     = iw_in;
    rs1_next    = rs_val[0];
    rs2_next    = rs_val[1];
    wb_en_next  = wb_en_dec;
    wb_reg_next = rd;
    if (stall_out) begin
      iw_next     = NOP_IW;
      rs1_next    = '0;
      rs2_next    = '0;
      wb_en_next  = 1'b0;
      wb_reg_next = 5'd0;
    end
  end

  // ID/EX pipeline register; reset overrides any pending stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= '0;
      iw_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      wb_en_reg  <= 1'b0;
      wb_reg_reg <= 5'd0;
    end else begin
      pc_reg     <= pc_next;
      iw_reg     <= iw_next;
      rs1_reg    <= rs1_next;
      rs2_reg    <= rs2_next;
      wb_en_reg  <= wb_en_next;
      wb_reg_reg <= wb_reg_next;
    end
  end

  assign pc_out       = pc_reg;
  assign iw_out       = iw_reg;
  assign rs1_data_out = rs1_reg;
  assign rs2_data_out = rs2_reg;
  assign wb_en_out    = wb_en_reg;
  assign wb_reg_out   = wb_reg_reg;

`ifdef RV32I_ID_PERF_CNT_EN
  logic        rs_fwd [2];
  logic        fwd_any;
  logic [31:0] stall_cnt_reg, fwd_cnt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign rs_fwd[gi] = rs_used[gi] && (rs_addr[gi] != 5'd0) &&
                          ((df_ex_enable  && (df_ex_reg  == rs_addr[gi])) ||
                           (df_mem_enable && (df_mem_reg == rs_addr[gi])));
    end
  endgenerate

  assign fwd_any = rs_fwd[0] || rs_fwd[1];

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall_out && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (!stall_out && fwd_any && (fwd_cnt_reg != 32'hFFFF_FFFF)) begin
        fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fwd_cnt   = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_rv32i_id_operand_fetch.sv
// tb_rv32i_id_operand_fetch: directed vectors with a scoreboard queue.
// The driver pushes one expectation per cycle; the monitor pops and
// compares after each rising edge.
module tb_rv32i_id_operand_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in, iw_in;
  logic        df_ex_enable, df_ex_is_load, df_mem_enable, wb_en_in;
  logic [4:0]  df_ex_reg, df_mem_reg, wb_reg_in;
  logic [31:0] df_ex_data, df_mem_data, wb_data_in;
  logic        stall_out;
  logic [31:0] pc_out, iw_out, rs1_data_out, rs2_data_out;
  logic        wb_en_out;
  logic [4:0]  wb_reg_out;
`ifdef RV32I_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  rv32i_id_operand_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .iw_in         (iw_in),
    .df_ex_enable  (df_ex_enable),
    .df_ex_reg     (df_ex_reg),
    .df_ex_data    (df_ex_data),
    .df_ex_is_load (df_ex_is_load),
    .df_mem_enable (df_mem_enable),
    .df_mem_reg    (df_mem_reg),
    .df_mem_data   (df_mem_data),
    .wb_en_in      (wb_en_in),
    .wb_reg_in     (wb_reg_in),
    .wb_data_in    (wb_data_in),
    .stall_out     (stall_out),
    .pc_out        (pc_out),
    .iw_out        (iw_out),
    .rs1_data_out  (rs1_data_out),
    .rs2_data_out  (rs2_data_out),
    .wb_en_out     (wb_en_out),
    .wb_reg_out    (wb_reg_out)
`ifdef RV32I_ID_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .fwd_cnt       (fwd_cnt)
`endif
  );

  typedef struct {
    string       name;
    bit          chk_stall;
    bit          exp_stall;
    bit          chk_out;
    bit          chk_ops;
    logic [31:0] pc;
    logic [31:0] iw;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        wb_en;
    logic [4:0]  wb_reg;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input bit cs, input bit st, input bit co,
                              input bit cops, input logic [31:0] pc, input logic [31:0] iw,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic we, input logic [4:0] wr);
    exp_t e;
    e.name = n; e.chk_stall = cs; e.exp_stall = st; e.chk_out = co; e.chk_ops = cops;
    e.pc = pc; e.iw = iw; e.rs1 = r1; e.rs2 = r2; e.wb_en = we; e.wb_reg = wr;
    return e;
  endfunction

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", n, f, act, req);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; pc_in = '0; iw_in = '0;
    df_ex_enable = 1'b0; df_ex_reg = '0; df_ex_data = '0; df_ex_is_load = 1'b0;
    df_mem_enable = 1'b0; df_mem_reg = '0; df_mem_data = '0;
    wb_en_in = 1'b0; wb_reg_in = '0; wb_data_in = '0;
  endtask

  // Monitor: stall_out is sampled on the edge it acts on, registers just after
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(posedge clk);
      s = stall_out;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_stall) cmp(e.name, "stall_out", {31'd0, s}, {31'd0, e.exp_stall});
        if (e.chk_out) begin
          cmp(e.name, "pc_out", pc_out, e.pc);
          cmp(e.name, "iw_out", iw_out, e.iw);
          cmp(e.name, "wb_en_out", {31'd0, wb_en_out}, {31'd0, e.wb_en});
          cmp(e.name, "wb_reg_out", {27'd0, wb_reg_out}, {27'd0, e.wb_reg});
        end
        if (e.chk_ops) begin
          cmp(e.name, "rs1_data_out", rs1_data_out, e.rs1);
          cmp(e.name, "rs2_data_out", rs2_data_out, e.rs2);
        end
        $display("txn %-14s pc=%08h iw=%08h rs1=%08h rs2=%08h wb=%0b/%0d stall=%0b",
                 e.name, pc_out, iw_out, rs1_data_out, rs2_data_out, wb_en_out, wb_reg_out, s);
      end
    end
  end

  // Driver: new inputs on each falling edge, expectation pushed alongside
  initial begin
    clear_inputs();
    reset = 1'b1;

    @(negedge clk); clear_inputs(); reset = 1'b1;
    exp_q.push_back(mk("reset", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h100; iw_in = 32'h0000_0013;
    wb_en_in = 1; wb_reg_in = 5; wb_data_in = 32'hDEAD_BEEF;
    exp_q.push_back(mk("wb_x5", 1, 0, 1, 1, 32'h100, 32'h13, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h104; iw_in = 32'h0002_8333;
    exp_q.push_back(mk("read_x5", 1, 0, 1, 1, 32'h104, 32'h0002_8333, 32'hDEAD_BEEF, 0, 1, 6));

    @(negedge clk); clear_inputs(); pc_in = 32'h108; iw_in = 32'h0003_8433;
    df_ex_enable = 1; df_ex_reg = 7; df_ex_data = 32'h11;
    df_mem_enable = 1; df_mem_reg = 7; df_mem_data = 32'h22;
    wb_en_in = 1; wb_reg_in = 7; wb_data_in = 32'h33;
    exp_q.push_back(mk("fwd_ex", 1, 0, 1, 1, 32'h108, 32'h0003_8433, 32'h11, 0, 1, 8));

    @(negedge clk); clear_inputs(); pc_in = 32'h10C; iw_in = 32'h0003_8433;
    df_mem_enable = 1; df_mem_reg = 7; df_mem_data = 32'h22;
    wb_en_in = 1; wb_reg_in = 7; wb_data_in = 32'h33;
    exp_q.push_back(mk("fwd_mem", 1, 0, 1, 1, 32'h10C, 32'h0003_8433, 32'h22, 0, 1, 8));

    @(negedge clk); clear_inputs(); pc_in = 32'h110; iw_in = 32'h0003_8433;
    wb_en_in = 1; wb_reg_in = 7; wb_data_in = 32'h33;
    exp_q.push_back(mk("fwd_wb", 1, 0, 1, 1, 32'h110, 32'h0003_8433, 32'h33, 0, 1, 8));

    @(negedge clk); clear_inputs(); pc_in = 32'h114; iw_in = 32'h0003_8433;
    exp_q.push_back(mk("rf_x7", 1, 0, 1, 1, 32'h114, 32'h0003_8433, 32'h33, 0, 1, 8));

    @(negedge clk); clear_inputs(); pc_in = 32'h118; iw_in = 32'h0090_A023;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("lu_stall_rs2", 1, 1, 1, 1, 32'h118, 32'h13, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h118; iw_in = 32'h0090_A023;
    df_mem_enable = 1; df_mem_reg = 9; df_mem_data = 32'h55;
    exp_q.push_back(mk("lu_resume", 1, 0, 1, 1, 32'h118, 32'h0090_A023, 0, 32'h55, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h11C; iw_in = 32'h0014_8513;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("lu_stall_rs1", 1, 1, 1, 1, 32'h11C, 32'h13, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h120; iw_in = 32'h1234_54B7;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("lui_nostall", 1, 0, 1, 1, 32'h120, 32'h1234_54B7, 0, 0, 1, 9));

    @(negedge clk); clear_inputs(); pc_in = 32'h124; iw_in = 32'h0004_84B7;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("lui_rs1fld", 1, 0, 1, 0, 32'h124, 32'h0004_84B7, 0, 0, 1, 9));

    @(negedge clk); clear_inputs(); pc_in = 32'h128; iw_in = 32'h0090_8513;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("opimm_rs2fld", 1, 0, 1, 0, 32'h128, 32'h0090_8513, 0, 0, 1, 10));

    @(negedge clk); clear_inputs(); pc_in = 32'h12C; iw_in = 32'h0000_0033;
    df_ex_enable = 1; df_ex_reg = 0; df_ex_data = 32'hAAAA; df_ex_is_load = 1;
    wb_en_in = 1; wb_reg_in = 0; wb_data_in = 32'hFFFF_FFFF;
    exp_q.push_back(mk("x0_bypass", 1, 0, 1, 1, 32'h12C, 32'h33, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h130; iw_in = 32'h0000_00B3;
    exp_q.push_back(mk("x0_read", 1, 0, 1, 1, 32'h130, 32'hB3, 0, 0, 1, 1));

    @(negedge clk); clear_inputs(); reset = 1; pc_in = 32'h134; iw_in = 32'h0090_A023;
    df_ex_enable = 1; df_ex_reg = 9; df_ex_data = 32'hBAD; df_ex_is_load = 1;
    exp_q.push_back(mk("reset_stall", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

    @(negedge clk); clear_inputs(); pc_in = 32'h140; iw_in = 32'h0072_85B3;
    exp_q.push_back(mk("post_reset_rf", 1, 0, 1, 1, 32'h140, 32'h0072_85B3, 0, 0, 1, 11));

    @(negedge clk); clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
